imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Boot-time program loader upstream of the processor core. Receives a byte stream over a
//  valid/ready interface, packs bytes MSB-first into WORD_W-bit instruction words and writes
//  them to consecutive instruction-memory addresses starting at 0. Holds the core (cpu_hold)
//  until a load completes, so the core starts fetching at PC 0 with a complete program image.
// PARAMETERS
//  WORD_W  16  instruction width in bits; must be a multiple of 8; BPW = WORD_W/8 bytes per word
//  ADDR_W  12  instruction-memory address width (word addressed)
// PORTS
//  clk       in   1         clock, all state updates on rising edge
//  rst       in   1         asynchronous, active-low reset
//  start     in   1         load request, sampled in IDLE/DONE only
//  len       in   ADDR_W+1  number of words to load, latched when start is accepted
//  abort     in   1         cancel load in progress
//  in_data   in   8         stream byte
//  in_valid  in   1         in_data valid
//  in_ready  out  1         loader can accept a byte
//  im_we     out  1         instruction-memory write strobe, one cycle per word
//  im_addr   out  ADDR_W    write address
//  im_wdata  out  WORD_W    assembled word
//  cpu_hold  out  1         1 = core held in reset/stalled
//  busy      out  1         load in progress (LOAD or WRITE)
//  done      out  1         last load completed successfully (level)
//  err       out  1         last request rejected or aborted (level)
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; in_ready=0, im_we=0, im_addr=0, im_wdata=0, cpu_hold=1,
//   busy=0, done=0, err=0; byte and word counters 0. Reset mid-load discards the partial word.
//  States: IDLE, LOAD, WRITE, DONE.
//  IDLE/DONE + start: if 1 <= len <= 2**ADDR_W -> LOAD, latch len, clear counters, im_addr=0,
//   cpu_hold=1, done=0, err=0. Otherwise -> stay/return to IDLE, err=1, done=0, cpu_hold=1.
//  LOAD: in_ready=1. Byte accepted iff in_valid & in_ready on a rising edge:
//   im_wdata <= {im_wdata[WORD_W-9:0], in_data}; byte_cnt++. On the BPW-th accepted byte
//   -> WRITE next cycle, byte_cnt=0. in_valid=0 cycles insert no bytes (any number allowed).
//  WRITE (exactly 1 cycle): im_we=1, in_ready=0, im_addr/im_wdata stable. Next edge:
//   word_cnt++; if word_cnt+1 == len -> DONE (im_addr unchanged); else im_addr++ -> LOAD.
//  DONE: done=1, cpu_hold=0, busy=0, in_ready=0; holds until new start or reset.
//  busy=1 exactly in LOAD and WRITE. im_we=1 only in WRITE.
//  start while busy: ignored. abort while busy: -> IDLE next edge, err=1, done=0, cpu_hold=1,
//   partial word dropped, no im_we that cycle even if in WRITE (abort wins over write).
//  abort in IDLE/DONE: ignored. Simultaneous start+abort in IDLE/DONE: start processed.
//  len = 2**ADDR_W: im_addr reaches 2**ADDR_W-1 on the final word and never wraps to 0.
//  Throughput: BPW accept cycles + 1 write cycle per word; latency from last byte of a word
//   to im_we = 1 cycle; from last word's im_we to done=1 = 1 cycle.
// TESTING
//  1. Reset: rst=0 mid-LOAD after 1 byte -> all outputs at reset values asynchronously,
//     cpu_hold=1; following start reloads from im_addr=0.
//  2. start, len=2, stream 12 34 56 78 with in_valid=1 -> im_we at addr 0 data 16'h1234,
//     im_we at addr 1 data 16'h5678, done=1 and cpu_hold=0 one cycle after the second write.
//  3. Same stream with in_valid toggling 1/0 each cycle -> identical writes, no extra im_we.
//  4. start with len=0 and len=4097 (ADDR_W=12) -> err=1, state IDLE, no im_we, cpu_hold=1.
//  5. abort asserted in the WRITE cycle of word 3 of len=5 -> no write for word 3, err=1,
//     done=0, cpu_hold=1; new start len=1 with bytes AB CD -> addr 0 = 16'hABCD, done=1.
//  6. start pulsed during LOAD -> ignored, len/counters unchanged; full-depth load len=4096
//     -> last write at addr 12'hFFF, done=1, im_addr stays 12'hFFF.

Source files
------------

// File: rtl/imem_loader.sv
// Boot-time program loader: packs a byte stream MSB-first into instruction words,
// writes them from address 0 upward and holds the core until the image is complete.
module imem_loader #(
   parameter int WORD_W = 16,
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W:0]   len,
   input  logic              abort,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [WORD_W-1:0] im_wdata,
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              err
);
   localparam int BPW = WORD_W / 8;
   localparam int CNT_W = (BPW > 1) ? $clog2(BPW) : 1;
   localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [ADDR_W:0] ONE_W = {{ADDR_W{1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BPW - 1);
   localparam logic [CNT_W-1:0] ONE_B = CNT_W'(1);
   localparam logic [ADDR_W-1:0] ONE_A = ADDR_W'(1);

   typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

   state_t           state;
   logic [ADDR_W:0]  lenReg;
   logic [ADDR_W:0]  wordCnt;
   logic [CNT_W-1:0] byteCnt;
   logic             weReg;
   logic             lenOk;
   logic             inLoad;

   assign lenOk  = (len != '0) && (len <= MAX_LEN);
   assign inLoad = (state == LOAD) || (state == WRITE);
   // An abort arriving in the WRITE cycle must kill that cycle's strobe.
   assign im_we  = weReg & ~abort;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         in_ready <= 1'b0;
         weReg    <= 1'b0;
         im_addr  <= '0;
         im_wdata <= '0;
         cpu_hold <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         byteCnt  <= '0;
         wordCnt  <= '0;
         lenReg   <= '0;
      end else if (inLoad && abort) begin
         state    <= IDLE;
         in_ready <= 1'b0;
         weReg    <= 1'b0;
         cpu_hold <= 1'b1;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b1;
         byteCnt  <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  done     <= 1'b0;
                  cpu_hold <= 1'b1;
                  if (lenOk) begin
                     state    <= LOAD;
                     lenReg   <= len;
                     byteCnt  <= '0;
                     wordCnt  <= '0;
                     im_addr  <= '0;
                     err      <= 1'b0;
                     busy     <= 1'b1;
                     in_ready <= 1'b1;
                  end else begin
                     state <= IDLE;
                     err   <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (in_valid) begin
                  im_wdata <= (im_wdata << 8) | WORD_W'(in_data);
                  if (byteCnt == LAST_BYTE) begin
                     byteCnt  <= '0;
                     state    <= WRITE;
                     in_ready <= 1'b0;
                     weReg    <= 1'b1;
                  end else begin
                     byteCnt <= byteCnt + ONE_B;
                  end
               end
            end
            WRITE: begin
               weReg   <= 1'b0;
               wordCnt <= wordCnt + ONE_W;
               // Final word leaves im_addr on the last address instead of wrapping.
               if ((wordCnt + ONE_W) == lenReg) begin
                  state    <= DONE;
                  done     <= 1'b1;
                  cpu_hold <= 1'b0;
                  busy     <= 1'b0;
               end else begin
                  im_addr  <= im_addr + ONE_A;
                  state    <= LOAD;
                  in_ready <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a driver pushes the words a load should produce,
// a monitor pops and compares them on every write strobe.
`timescale 1ns/1ps
module tb_imem_loader;
   localparam int WORD_W = 16;
   localparam int ADDR_W = 12;
   localparam int BPW = WORD_W / 8;

   logic clk = 1'b0, rst = 1'b0, start = 1'b0, abort = 1'b0, in_valid = 1'b0;
   logic [ADDR_W:0] len = '0;
   logic [7:0] in_data = '0;
   logic in_ready, im_we, cpu_hold, busy, done, err;
   logic [ADDR_W-1:0] im_addr;
   logic [WORD_W-1:0] im_wdata;

   int checks = 0, failures = 0;
   int cyc = 0, lastWeCyc = 0;

   typedef struct packed {
      logic [ADDR_W-1:0] a;
      logic [WORD_W-1:0] d;
   } exp_t;
   exp_t expQ[$];
   logic [7:0] byteBuf [0:BPW*4096-1];

   imem_loader #(.WORD_W(WORD_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .start(start), .len(len), .abort(abort),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
      .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic slot();
      @(negedge clk);
      #1;
   endtask

   // Monitor: every write strobe must match the head of the expected queue.
   initial begin
      forever begin
         @(negedge clk);
         #3;
         if (im_we === 1'b1) begin
            lastWeCyc = cyc;
            if (expQ.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_write actual addr=%0h data=%0h required=no write", im_addr, im_wdata);
            end else begin
               exp_t e;
               e = expQ.pop_front();
               check("write_addr", 32'(im_addr), 32'(e.a));
               check("write_data", 32'(im_wdata), 32'(e.d));
               check("ready_low_in_write", 32'(in_ready), 32'd0);
            end
         end
      end
   end

   task automatic checkIdleErr(input string tag);
      check({tag, "_err"}, 32'(err), 32'd1);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_hold"}, 32'(cpu_hold), 32'd1);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_ready"}, 32'(in_ready), 32'd0);
   endtask

   // mode: 0 valid always, 1 valid toggling, 2 random valid.
   // abortAfter: abort is raised in the cycle after that many bytes were accepted (-1 = never).
   task automatic runLoad(input int nWords, input int mode, input int abortAfter,
                          input int pulseSlot, input bit keepBytes, input bit startAbort);
      int total, accepted, expWords, sIdx;
      bit acc, aborted;
      logic [WORD_W-1:0] w;
      total = nWords * BPW;
      if (!keepBytes)
         for (int i = 0; i < total; i++) byteBuf[i] = 8'($urandom);
      if (abortAfter < 0) expWords = nWords;
      else if (abortAfter == 0) expWords = 0;
      else if (abortAfter % BPW == 0) expWords = abortAfter / BPW - 1;
      else expWords = abortAfter / BPW;
      for (int k = 0; k < expWords; k++) begin
         w = '0;
         for (int b = 0; b < BPW; b++) w = (w << 8) | WORD_W'(byteBuf[k*BPW+b]);
         expQ.push_back('{a: ADDR_W'(k), d: w});
      end
      slot();
      start = 1'b1;
      len = (ADDR_W+1)'(nWords);
      abort = startAbort;
      slot();
      start = 1'b0;
      abort = 1'b0;
      accepted = 0;
      aborted = 1'b0;
      sIdx = 0;
      forever begin
         if (abortAfter >= 0 && accepted == abortAfter) begin
            in_valid = 1'b0;
            start = 1'b0;
            abort = 1'b1;
            slot();
            abort = 1'b0;
            aborted = 1'b1;
            break;
         end
         if (accepted == total) break;
         if (sIdx > total * 10 + 100) begin
            check("byte_accept_timeout", 32'(accepted), 32'(total));
            break;
         end
         start = (sIdx == pulseSlot);
         if (start) len = (ADDR_W+1)'(1);
         case (mode)
            0: in_valid = 1'b1;
            1: in_valid = (sIdx[0] == 1'b0);
            default: in_valid = ($urandom_range(3) != 0);
         endcase
         in_data = byteBuf[accepted];
         acc = in_valid && in_ready;
         slot();
         sIdx++;
         if (acc) accepted++;
      end
      in_valid = 1'b0;
      start = 1'b0;
      if (aborted) begin
         checkIdleErr("abort");
         check("abort_pending_writes", 32'(expQ.size()), 32'd0);
      end else begin
         int n;
         n = 0;
         while (done !== 1'b1 && n < 20) begin
            slot();
            n++;
         end
         check("done", 32'(done), 32'd1);
         check("done_latency", 32'(cyc - lastWeCyc), 32'd1);
         check("hold_released", 32'(cpu_hold), 32'd0);
         check("busy_after_done", 32'(busy), 32'd0);
         check("err_after_done", 32'(err), 32'd0);
         check("pending_writes", 32'(expQ.size()), 32'd0);
         slot();
         slot();
         check("final_addr", 32'(im_addr), 32'(nWords - 1));
         check("done_level", 32'(done), 32'd1);
      end
      expQ.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      slot();
      slot();
      check("rst_ready", 32'(in_ready), 32'd0);
      check("rst_we", 32'(im_we), 32'd0);
      check("rst_hold", 32'(cpu_hold), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      rst = 1'b1;
      slot();

      // Asynchronous reset after one byte of a load
      start = 1'b1;
      len = (ADDR_W+1)'(3);
      slot();
      start = 1'b0;
      in_valid = 1'b1;
      in_data = 8'h5A;
      slot();
      in_valid = 1'b0;
      check("preload_busy", 32'(busy), 32'd1);
      rst = 1'b0;
      #1;
      check("arst_ready", 32'(in_ready), 32'd0);
      check("arst_we", 32'(im_we), 32'd0);
      check("arst_addr", 32'(im_addr), 32'd0);
      check("arst_wdata", 32'(im_wdata), 32'd0);
      check("arst_hold", 32'(cpu_hold), 32'd1);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_done", 32'(done), 32'd0);
      check("arst_err", 32'(err), 32'd0);
      #1;
      rst = 1'b1;

      // Two words, continuous and toggling valid
      byteBuf[0] = 8'h12; byteBuf[1] = 8'h34; byteBuf[2] = 8'h56; byteBuf[3] = 8'h78;
      runLoad(2, 0, -1, -1, 1'b1, 1'b0);
      abort = 1'b1;
      slot();
      abort = 1'b0;
      check("abort_in_done_ignored", 32'(done), 32'd1);
      runLoad(2, 1, -1, -1, 1'b1, 1'b0);

      // Out-of-range lengths
      slot();
      start = 1'b1;
      len = (ADDR_W+1)'(0);
      slot();
      start = 1'b0;
      checkIdleErr("len0");
      start = 1'b1;
      len = (ADDR_W+1)'(4097);
      slot();
      start = 1'b0;
      checkIdleErr("len4097");

      // Abort in the write cycle of word 3, then a clean one-word load
      runLoad(5, 2, 3 * BPW, -1, 1'b0, 1'b0);
      byteBuf[0] = 8'hAB; byteBuf[1] = 8'hCD;
      runLoad(1, 0, -1, -1, 1'b1, 1'b0);

      // start pulsed mid-load, start+abort together, full-depth load
      runLoad(6, 2, -1, 3, 1'b0, 1'b0);
      runLoad(3, 2, -1, -1, 1'b0, 1'b1);
      runLoad(4096, 0, -1, -1, 1'b0, 1'b0);

      for (int it = 0; it < 10; it++) begin
         int nw, ab;
         nw = $urandom_range(20, 1);
         ab = ($urandom_range(3) == 0) ? $urandom_range(nw * BPW, 0) : -1;
         runLoad(nw, 2, ab, $urandom_range(2 * nw * BPW, 0), 1'b0, 1'($urandom_range(1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
